// File: rtl/gcd_operand_feeder.sv
// gcd_operand_feeder: buffers operand pairs and sequences the GCD Processor's Reset/Enter/Input pins per pair, returning Output or an error.
module gcd_operand_feeder #(
  parameter int DEPTH     = 4,
  parameter int ENTER_GAP = 15,
  parameter int TIMEOUT   = 1024
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       InValid,
  output logic       InReady,
  input  logic [7:0] InX,
  input  logic [7:0] InY,
  output logic       ResValid,
  input  logic       ResReady,
  output logic [7:0] ResData,
  output logic       ResError,
  output logic       Busy,
  output logic       ProcReset,
  output logic       ProcEnter,
  output logic [7:0] ProcInput,
  input  logic       ProcHalt,
  input  logic [7:0] ProcOutput
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2((TIMEOUT > ENTER_GAP ? TIMEOUT : ENTER_GAP) + 1);
  typedef enum logic [2:0] {IDLE, PRST, LOADX, GAP, LOADY, WAIT_HALT, RESULT} state_t;
  state_t state_q, state_d;
  logic [15:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [7:0] x_q, x_d, y_q, y_d, res_data_q, res_data_d, pin_q, pin_d;
  logic res_err_q, res_err_d, res_valid_q, res_valid_d, prst_q, prst_d, pent_q, pent_d;
  logic push, pop;
  logic [15:0] head;
  assign InReady   = cnt_q != CW'(DEPTH);
  assign push      = InValid && InReady;
  assign head      = mem_q[rd_q];
  assign Busy      = state_q != IDLE;
  assign ResValid  = res_valid_q;
  assign ResData   = res_data_q;
  assign ResError  = res_err_q;
  assign ProcReset = prst_q;
  assign ProcEnter = pent_q;
  assign ProcInput = pin_q;
  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_q] <= {InX, InY};
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      tmr_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      prst_q      <= 1'b0;
      pent_q      <= 1'b0;
      pin_q       <= '0;
    end else begin
      wr_q        <= wr_q + AW'(push);
      rd_q        <= rd_q + AW'(pop);
      cnt_q       <= cnt_q + CW'(push) - CW'(pop);
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      prst_q      <= prst_d;
      pent_q      <= pent_d;
      pin_q       <= pin_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    x_d        = x_q;
    y_d        = y_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop = 1'b1;
        x_d = head[15:8];
        y_d = head[7:0];
        if (head[15:8] == '0 || head[7:0] == '0) begin
          state_d    = RESULT;
          res_data_d = '0;
          res_err_d  = 1'b1;
        end else state_d = PRST;
      end
      PRST: state_d = LOADX;
      LOADX: begin
        tmr_d   = '0;
        state_d = ENTER_GAP == 0 ? LOADY : GAP;
      end
      GAP: begin
        tmr_d   = tmr_q + 1'b1;
        state_d = tmr_q == TW'(ENTER_GAP - 1) ? LOADY : GAP;
      end
      LOADY: begin
        tmr_d   = '0;
        state_d = WAIT_HALT;
      end
      WAIT_HALT: begin
        tmr_d = tmr_q + 1'b1;
        if (ProcHalt) begin
          state_d    = RESULT;
          res_data_d = ProcOutput;
          res_err_d  = 1'b0;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d    = RESULT;
          res_data_d = '0;
          res_err_d  = 1'b1;
        end
      end
      RESULT: state_d = ResReady ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
    // Pins are registered from the next state so they line up exactly with the state they belong to.
    res_valid_d = state_d == RESULT;
    prst_d      = state_d == PRST;
    pent_d      = state_d == LOADX || state_d == LOADY;
    pin_d       = (state_d == LOADX || state_d == GAP) ? x_q :
                  (state_d == LOADY || state_d == WAIT_HALT) ? y_q : pin_q;
  end
endmodule
